// File: rtl/led7seg_pkg.sv
// Shared constants and anode helpers for the led7seg scan controller.
package led7seg_pkg;

    localparam int BCD_W       = 4;
    localparam int MAX_DIGITS  = 8;
    localparam int CLK_DIV_DEF = 100000;

    // Callers size-cast the result down to their own digit count.
    function automatic logic [MAX_DIGITS-1:0] an_off();
        return '1;
    endfunction

    function automatic logic [MAX_DIGITS-1:0] an_onehot_low(input logic [2:0] idx);
        return ~(MAX_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/led7seg_tick_gen.sv
// Digit-slot prescaler: counts 0..CLK_DIV-1 while enabled, ticks on the last count.
module led7seg_tick_gen
    import led7seg_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    output logic                       o_tick,
    output logic [$clog2(CLK_DIV)-1:0] o_count
);

    localparam int CNT_W = $clog2(CLK_DIV);

    assign o_tick = i_en && (o_count == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_count <= '0;
        else if (o_tick)
            o_count <= '0;
        else if (i_en)
            o_count <= o_count + CNT_W'(1);
    end

endmodule

// File: rtl/led7seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display with a double-buffered BCD frame.
// Define LED7SEG_BLANK_EN to add BLANK_CYCLES of anode dead time at the start of each slot.
module led7seg_scan_ctrl
    import led7seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = CLK_DIV_DEF,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic                        i_load,
    input  logic [BCD_W*NUM_DIGITS-1:0] i_data,
    output logic [BCD_W-1:0]            o_digit,
    output logic [NUM_DIGITS-1:0]       o_an,
    output logic                        o_frame,
    output logic                        o_pending
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = NUM_DIGITS'(an_off());
`ifdef LED7SEG_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic [NUM_DIGITS-1:0][BCD_W-1:0] r_active;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] r_pend_data;
    logic [IDX_W-1:0]                 r_idx;

    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_blank;
    logic [CNT_W-1:0]      w_count;
    logic [NUM_DIGITS-1:0] w_an_sel;

    led7seg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .o_tick  (w_tick),
        .o_count (w_count)
    );

    assign w_wrap   = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_blank  = BLANK_ON && (w_count < CNT_W'(BLANK_CYCLES));
    assign w_an_sel = NUM_DIGITS'(an_onehot_low(3'(r_idx)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx       <= '0;
            r_active    <= '0;
            r_pend_data <= '0;
            o_pending   <= 1'b0;
            o_digit     <= '0;
            o_an        <= AN_OFF;
            o_frame     <= 1'b0;
        end else begin
            // A load landing on the wrap tick bypasses the pending buffer.
            if (w_wrap && i_load) begin
                r_active  <= i_data;
                o_pending <= 1'b0;
            end else if (w_wrap && o_pending) begin
                r_active  <= r_pend_data;
                o_pending <= 1'b0;
            end else if (i_load) begin
                r_pend_data <= i_data;
                o_pending   <= 1'b1;
            end

            o_frame <= w_wrap;

            if (i_en) begin
                if (w_tick)
                    r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
                o_an    <= w_blank ? AN_OFF : w_an_sel;
                o_digit <= r_active[r_idx];
            end else begin
                o_an <= AN_OFF;
            end
        end
    end

endmodule

// File: tb/tb_led7seg_scan_ctrl.sv
// Self-checking bench for led7seg_scan_ctrl (4 digits, 4 clocks per slot) against a time-based model.
module tb_led7seg_scan_ctrl;

    localparam int N  = 4;
    localparam int CD = 4;
    localparam int BC = 1;
`ifdef LED7SEG_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst = 1'b1, i_en = 1'b0, i_load = 1'b0;
    logic [15:0] i_data = '0;
    logic [3:0]  o_digit;
    logic [3:0]  o_an;
    logic        o_frame, o_pending;

    int errs = 0, checks = 0;

    // Model: position in the scan derived from the number of enabled cycles.
    int          ecnt;
    logic [15:0] shown, pendv;
    bit          pend;
    logic [3:0]  e_dig, e_an;
    bit          e_frame;

    led7seg_scan_ctrl #(.NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_load(i_load), .i_data(i_data),
        .o_digit(o_digit), .o_an(o_an), .o_frame(o_frame), .o_pending(o_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit en, input bit ld, input logic [15:0] d);
        int  slot, phase;
        bit  wrap;
        if (rst) begin
            ecnt = 0; shown = '0; pendv = '0; pend = 0;
            e_dig = '0; e_an = 4'hF; e_frame = 0;
            return;
        end
        wrap = 0;
        if (en) begin
            phase   = ecnt % CD;
            slot    = ecnt / CD;
            e_an    = (BLANK && phase < BC) ? 4'hF : 4'((~(1 << slot)) & 4'hF);
            e_dig   = shown[slot*4 +: 4];
            wrap    = (phase == CD-1) && (slot == N-1);
            ecnt    = (ecnt + 1) % (N*CD);
        end else begin
            e_an = 4'hF;
        end
        e_frame = wrap;
        if (wrap && ld) begin
            shown = d; pend = 0;
        end else if (wrap && pend) begin
            shown = pendv; pend = 0;
        end else if (ld) begin
            pendv = d; pend = 1;
        end
    endtask

    task automatic check_all();
        chk("an", 32'(o_an), 32'(e_an));
        chk("digit", 32'(o_digit), 32'(e_dig));
        chk("frame", 32'(o_frame), 32'(e_frame));
        chk("pending", 32'(o_pending), 32'(pend));
    endtask

    task automatic step(input bit en, input bit ld, input logic [15:0] d);
        i_rst = 1'b0; i_en = en; i_load = ld; i_data = d;
        @(posedge clk);
        model_edge(0, en, ld, d);
        #1 check_all();
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_en = 1'b1; i_load = 1'b1; i_data = 16'hABCD;
        @(posedge clk);
        model_edge(1, 0, 0, '0);
        #1 check_all();
    endtask

    task automatic align(input int target, input string tag);
        bit found = 0;
        for (int k = 0; k < 64 && !found; k++) begin
            if (ecnt == target) found = 1;
            else step(1, 0, '0);
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        do_reset();
        do_reset();

        // Free-running scan with an all-zero frame.
        for (int i = 0; i < 36; i++) step(1, 0, '0);

        // Single load mid-frame.
        align(5, "align_load1");
        step(1, 1, 16'h4321);
        for (int i = 0; i < 32; i++) step(1, 0, '0);

        // Two loads before the wrap: last one wins.
        align(3, "align_load2");
        step(1, 1, 16'h1111);
        step(1, 0, '0);
        step(1, 1, 16'h9876);
        for (int i = 0; i < 30; i++) step(1, 0, '0);

        // Load coincident with the wrap tick.
        align(N*CD-1, "align_wrap");
        step(1, 1, 16'h5555);
        for (int i = 0; i < 8; i++) step(1, 0, '0);

        // Disable mid-slot at idx 2, with a load while dark.
        align(2*CD+1, "align_dis");
        for (int i = 0; i < 10; i++) step(0, (i == 4), 16'h0A0F);
        for (int i = 0; i < 24; i++) step(1, 0, '0);

        // Reset mid-scan with a pending frame.
        step(1, 1, 16'hFEDC);
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0, '0);

        // Randomized enable/load traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom % 8) != 0, ($urandom % 6) == 0, 16'($urandom));

        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, '0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
